tag_return_queue: RTL
=====================

# tag_return_queue

Retire-side writer for the tag free list. Collects physical tags released by the commit stage, up to two per cycle, in a small in-order buffer. Drains them into the free list's single write port (`write_tag` / `write_tag_source`) at one per cycle, paced by the free list's `freespace`. Sits between the commit logic and `tag_fifo`, so returned tags become reallocatable by the rename/microcode side.

## Interface
Parameters:
- `DEPTH`, 8 — buffer entries; even, ≥ 4.
- `TAG_W`, 8 — tag width; matches `tag_fifo`.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `retire_valid_0` in 1 — lane 0 returns a tag this cycle.
- `retire_tag_0` in TAG_W — lane 0 tag.
- `retire_valid_1` in 1 — lane 1 returns a tag this cycle.
- `retire_tag_1` in TAG_W — lane 1 tag.
- `retire_ready` out 1 — room for two tags; lanes are accepted only when high.
- `write_tag` out 1 — registered; one-cycle write strobe to the free list.
- `write_tag_source` out TAG_W — registered; tag being written.
- `freespace` in 8 — free-list remaining capacity, as reported by `tag_fifo`.
- `pending` out $clog2(DEPTH+1) — registered buffer occupancy.
- `dup_error` out 1 — sticky duplicate-return flag (see Configuration).

## Operation
- Circular buffer with head/tail pointers that wrap modulo DEPTH, plus a count register.
- Accept:
  - `retire_ready = (pending <= DEPTH-2)`, computed from the registered count only and never from the valids.
  - On a rising edge with `retire_ready` high, valid lanes are pushed in lane order: lane 0, then lane 1.
  - Lane 1 alone pushes one entry. Both lanes push two.
  - Valids while `retire_ready` is low are ignored; the sender must hold them.
- Drain:
  - Credit rule: `credit_ok = freespace > (write_tag ? 1 : 0)`. This accounts for the write already in flight that `freespace` has not yet reflected.
  - If `pending != 0` and `credit_ok`: next cycle `write_tag=1`, `write_tag_source=head`, head advances, one entry popped.
  - Otherwise `write_tag=0` and `write_tag_source` holds its value.
- Simultaneous push and pop in one cycle: `pending_next = pending + pushes - pop`, where pop ∈ {0,1} and pushes ∈ {0,1,2}.
- A slot freed by this cycle's pop does not raise `retire_ready` until the next cycle.
- Never writes when `freespace == 0`. Never pops when empty. Never overruns, because of the `retire_ready` rule.
- Reset mid-operation: buffered tags are discarded. The system reset re-initialises the free list.

## Timing
- Reset values: `write_tag=0`, `write_tag_source=0`, `pending=0`, `dup_error=0`, `retire_ready=1`, head=tail=0.
- Latency: a tag accepted at edge N can appear on `write_tag_source` with `write_tag=1` at edge N+1 at the earliest, given credit and an empty buffer.
- Throughput: one drained tag per cycle; up to two accepted per cycle.
- Ordering is strict FIFO: lane 0 before lane 1, and older cycles first.

## Configuration
- `TAG_RET_DUPCHK_EN` defined:
  - A 2^TAG_W-bit "queued" bitmap tracks tags currently buffered. A bit is set on push and cleared on pop.
  - An incoming tag whose bit is already set is dropped and sets `dup_error`, which stays high until reset.
  - Both lanes carrying the same tag in the same cycle: lane 1 is dropped and `dup_error` is set.
  - A tag popped and re-pushed in the same cycle is accepted.
- `TAG_RET_DUPCHK_EN` not defined: no bitmap, `dup_error` tied to 0, and every valid lane is pushed.

## Test plan
- Reset, then lane 0 valid with tag 0x05 for one cycle and `freespace=126` → next edge `write_tag=1`, `write_tag_source=0x05`; the following edge `write_tag=0`, `pending=0`.
- Both lanes with tags 0x10/0x11 every cycle for 6 cycles, `freespace=126` → `retire_ready` drops once `pending>6`. Output order is 0x10, 0x11, … with one strobe per cycle and no loss.
- `freespace=0` with 3 tags buffered → `write_tag` stays 0 and `pending=3`. Raise `freespace` to 1 → exactly one write. The next write is issued only after `freespace` reads ≥ 2 while `write_tag` is high, or ≥ 1 once `write_tag` is low.
- Fill to `pending=DEPTH` with `freespace=0`: `retire_ready=0` and offered tags are not accepted. Release credit → drain resumes in order, and head/tail wrap correctly across 2×DEPTH tags.
- Assert `reset` with 4 tags pending → the next edge gives `pending=0`, `write_tag=0`, and no buffered tag is ever written.
- With `TAG_RET_DUPCHK_EN`, both lanes carrying 0x22 → one entry is pushed and `dup_error=1` until reset. Without the macro → two entries are pushed and `dup_error=0`.

Source files
------------

// File: rtl/tag_return_queue.sv
// Retire-side tag return buffer: accepts up to two tags per cycle, drains one per cycle into the free list.
// Optional duplicate-return detection is enabled with `define TAG_RET_DUPCHK_EN.
module tag_return_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       retire_valid_0,
    input  logic [TAG_W-1:0]           retire_tag_0,
    input  logic                       retire_valid_1,
    input  logic [TAG_W-1:0]           retire_tag_1,
    output logic                       retire_ready,
    output logic                       write_tag,
    output logic [TAG_W-1:0]           write_tag_source,
    input  logic [7:0]                 freespace,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       dup_error
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Modulo-DEPTH pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + {{(PW-1){1'b0}}, n};
        if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, idx1;
    logic [CW-1:0]    count_q, count_d;
    logic             wt_q, wt_d;
    logic [TAG_W-1:0] src_q, src_d, head_tag;
    logic             ready, credit_ok, pop, push0, push1;
    logic [1:0]       n_push;

    assign ready     = (count_q <= CW'(DEPTH-2));
    // freespace lags our own write by a cycle, so an in-flight strobe consumes one credit.
    assign credit_ok = (freespace > {7'd0, wt_q});
    assign pop       = (count_q != '0) && credit_ok;
    assign head_tag  = mem_q[head_q];

`ifdef TAG_RET_DUPCHK_EN
    logic [2**TAG_W-1:0] queued_q, queued_d;
    logic                seen0, seen1, same, dup_q, dup_d;

    always_comb begin
        seen0 = queued_q[retire_tag_0] && !(pop && head_tag == retire_tag_0);
        seen1 = queued_q[retire_tag_1] && !(pop && head_tag == retire_tag_1);
        same  = retire_valid_0 && (retire_tag_0 == retire_tag_1);
        push0 = ready && retire_valid_0 && !seen0;
        push1 = ready && retire_valid_1 && !seen1 && !same;
        dup_d = dup_q || (ready && ((retire_valid_0 && seen0) ||
                                    (retire_valid_1 && (seen1 || same))));
        queued_d = queued_q;
        if (pop)   queued_d[head_tag]     = 1'b0;
        if (push0) queued_d[retire_tag_0] = 1'b1;
        if (push1) queued_d[retire_tag_1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            queued_q <= '0;
            dup_q    <= 1'b0;
        end else begin
            queued_q <= queued_d;
            dup_q    <= dup_d;
        end
    end

    assign dup_error = dup_q;
`else
    always_comb begin
        push0 = ready && retire_valid_0;
        push1 = ready && retire_valid_1;
    end

    assign dup_error = 1'b0;
`endif

    always_comb begin
        n_push  = {1'b0, push0} + {1'b0, push1};
        idx1    = push0 ? ptr_add(tail_q, 2'd1) : tail_q;
        tail_d  = ptr_add(tail_q, n_push);
        head_d  = pop ? ptr_add(head_q, 2'd1) : head_q;
        count_d = count_q + CW'(n_push) - CW'(pop);
        wt_d    = pop;
        src_d   = pop ? head_tag : src_q;
    end

    always_ff @(posedge clk) begin
        if (push0) mem_q[tail_q] <= retire_tag_0;
        if (push1) mem_q[idx1]   <= retire_tag_1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wt_q    <= 1'b0;
            src_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wt_q    <= wt_d;
            src_q   <= src_d;
        end
    end

    assign retire_ready     = ready;
    assign write_tag        = wt_q;
    assign write_tag_source = src_q;
    assign pending          = count_q;
endmodule
